// File: rtl/tmds_rx_channel.sv
// Single-lane TMDS receiver: word alignment from control tokens, 10b->8b/2b decode, lock tracking.
// Everything runs on the bit clock; decoded outputs are registered and qualified by word_valid.
`timescale 1ns/1ps
module tmds_rx_channel #(
  parameter int LOCK_COUNT = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic       shiftclk,
  input  logic       resetn,
  input  logic       serial_in,
  output logic       word_valid,
  output logic [9:0] tmds_word,
  output logic [7:0] vd,
  output logic [1:0] cd,
  output logic       de,
  output logic       locked
);

  localparam int HW = $clog2(LOCK_COUNT + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  // Handshake: word_valid is a one-cycle strobe with no back-pressure; tmds_word/vd/cd/de
  // are stable from that cycle until the next strobe, so a consumer samples them while word_valid=1.

  typedef enum logic {S_SEARCH = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t         state, state_d;
  // Only the upper 9 bits of the shift register are ever read, so only those are stored.
  logic [8:0]     sr_hi;
  logic [3:0]     phase, phase_d;
  logic [HW-1:0]  hits, hits_d, hits_inc;
  logic [IW-1:0]  idle, idle_d, idle_inc;
  logic [9:0]     win;
  logic           boundary;
  logic           is_tok;
  logic [1:0]     tok_cd;
  logic           wv_d, de_d;
  logic [9:0]     tmds_d;
  logic [7:0]     vd_d;
  logic [1:0]     cd_d;

  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] r;
    d    = q[9] ? ~q[7:0] : q[7:0];
    r    = '0;
    r[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      r[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return r;
  endfunction

  assign win      = {serial_in, sr_hi};
  assign boundary = (phase == 4'd9);
  // The lock flag is the FSM state itself, so it doubles as the state observation point.
  assign locked   = (state == S_LOCKED);

  always_comb begin
    is_tok = 1'b1;
    tok_cd = 2'b00;
    case (win)
      10'b1101010100: tok_cd = 2'b00;
      10'b0010101011: tok_cd = 2'b01;
      10'b0101010100: tok_cd = 2'b10;
      10'b1010101011: tok_cd = 2'b11;
      default:        is_tok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state;
    phase_d  = boundary ? 4'd0 : phase + 4'd1;
    hits_d   = hits;
    idle_d   = idle;
    hits_inc = hits + HW'(1);
    idle_inc = idle + IW'(1);
    wv_d     = 1'b0;
    tmds_d   = tmds_word;
    vd_d     = vd;
    cd_d     = cd;
    de_d     = de;
    case (state)
      S_SEARCH: begin
        if (is_tok) begin
          if (!boundary) begin
            // A token off the current grid defines a new grid: this edge becomes the boundary.
            phase_d  = 4'd0;
            hits_inc = HW'(1);
          end
          hits_d = hits_inc;
          if (hits_inc == HW'(LOCK_COUNT)) begin
            state_d = S_LOCKED;
            idle_d  = '0;
            wv_d    = 1'b1;
            tmds_d  = win;
            cd_d    = tok_cd;
            de_d    = 1'b0;
          end
        end else if (boundary) begin
          hits_d = '0;
        end
      end
      S_LOCKED: begin
        if (boundary) begin
          wv_d   = 1'b1;
          tmds_d = win;
          if (is_tok) begin
            cd_d   = tok_cd;
            de_d   = 1'b0;
            idle_d = '0;
          end else begin
            vd_d = tmds_decode(win);
            de_d = 1'b1;
            if (idle_inc == IW'(TIMEOUT)) begin
              state_d = S_SEARCH;
              hits_d  = '0;
              idle_d  = '0;
            end else begin
              idle_d = idle_inc;
            end
          end
        end
      end
      default: state_d = S_SEARCH;
    endcase
  end

  always_ff @(posedge shiftclk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_SEARCH;
      sr_hi      <= '0;
      phase      <= 4'd0;
      hits       <= '0;
      idle       <= '0;
      word_valid <= 1'b0;
      tmds_word  <= '0;
      vd         <= '0;
      cd         <= '0;
      de         <= 1'b0;
    end else begin
      state      <= state_d;
      sr_hi      <= win[9:1];
      phase      <= phase_d;
      hits       <= hits_d;
      idle       <= idle_d;
      word_valid <= wv_d;
      tmds_word  <= tmds_d;
      vd         <= vd_d;
      cd         <= cd_d;
      de         <= de_d;
    end
  end

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Directed bench for tmds_rx_channel: serial word driver, expected-word queue and a
// word_valid-triggered monitor that pops and compares each decoded word.
`timescale 1ns/1ps
module tb_tmds_rx_channel;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic       shiftclk;
  logic       resetn;
  logic       serial_in;
  logic       word_valid;
  logic [9:0] tmds_word;
  logic [7:0] vd;
  logic [1:0] cd;
  logic       de;
  logic       locked;

  // Expected entry layout: {locked, de, cd[1:0], vd[7:0], tmds_word[9:0]}
  logic [21:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          pend_chk = 0;
  logic        pend_lk = 0;
  string       pend_name = "";
  bit          gap_ok = 0;
  int          since_v = 0;

  tmds_rx_channel #(.LOCK_COUNT(8), .TIMEOUT(1024)) dut (
    .shiftclk  (shiftclk),
    .resetn    (resetn),
    .serial_in (serial_in),
    .word_valid(word_valid),
    .tmds_word (tmds_word),
    .vd        (vd),
    .cd        (cd),
    .de        (de),
    .locked    (locked)
  );

  // ---------------- clock ----------------
  initial begin
    shiftclk = 1'b0;
    forever #5 shiftclk = ~shiftclk;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [21:0] mk(input logic lk, input logic d, input logic [1:0] c,
                                     input logic [7:0] v, input logic [9:0] w);
    return {lk, d, c, v, w};
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_word_valid"}, {31'd0, word_valid}, 32'd0);
    check({tag, "_tmds_word"},  {22'd0, tmds_word},  32'd0);
    check({tag, "_vd"},         {24'd0, vd},         32'd0);
    check({tag, "_cd"},         {30'd0, cd},         32'd0);
    check({tag, "_de"},         {31'd0, de},         32'd0);
    check({tag, "_locked"},     {31'd0, locked},     32'd0);
  endtask

  // ---------------- drivers ----------------
  // A pending lock check runs at the first negedge of the next bit, i.e. right after
  // the edge that sampled the final bit of the previous word.
  task automatic drive_bit(input logic b);
    @(negedge shiftclk);
    if (pend_chk) begin
      check(pend_name, {31'd0, locked}, {31'd0, pend_lk});
      pend_chk = 0;
    end
    serial_in = b;
  endtask

  task automatic expect_lock(input string name, input logic lk);
    pend_chk  = 1;
    pend_lk   = lk;
    pend_name = name;
  endtask

  task automatic send_word(input logic [9:0] w, input bit has_exp, input logic [21:0] e);
    if (has_exp) exp_q.push_back(e);
    for (int i = 0; i < 10; i++) drive_bit(w[i]);
  endtask

  task automatic do_reset(input int n);
    @(negedge shiftclk);
    resetn = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge shiftclk);
      serial_in = 1'($urandom_range(0, 1));
    end
    resetn    = 1'b1;
    serial_in = 1'b0;
  endtask

  task automatic acquire(input string tag);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    for (int i = 0; i < 7; i++) send_word(T00, 0, '0);
    expect_lock({tag, "_unlocked_after_7"}, 1'b0);
    for (int i = 0; i < 5; i++) send_word(T00, 1, mk(1, 0, 2'b00, 8'h00, T00));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge shiftclk) begin
    logic [21:0] e;
    logic [21:0] a;
    if (!resetn) begin
      gap_ok  = 0;
      since_v = 0;
    end else begin
      since_v++;
      if (word_valid) begin
        if (gap_ok) check("wv_period", since_v, 32'd10);
        gap_ok  = locked;
        since_v = 0;
        a = {locked, de, cd, vd, tmds_word};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h expected no word at %0t", a, $time);
        end else begin
          e = exp_q.pop_front();
          check("decoded_word", {10'd0, a}, {10'd0, e});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    resetn    = 1'b0;
    serial_in = 1'b0;

    // Reset with random line activity
    for (int i = 0; i < 20; i++) begin
      @(negedge shiftclk);
      serial_in = 1'($urandom_range(0, 1));
    end
    check_outputs_zero("reset");
    resetn    = 1'b1;
    serial_in = 1'b0;

    // Acquisition: 3 junk bits, 12 CD=00 tokens
    acquire("acq");

    // Decode after lock
    send_word(10'h100, 1, mk(1, 1, 2'b00, 8'h00, 10'h100));
    send_word(10'h200, 1, mk(1, 1, 2'b00, 8'hFF, 10'h200));
    send_word(T11,     1, mk(1, 0, 2'b11, 8'hFF, T11));
    send_word(10'h30F, 1, mk(1, 1, 2'b11, 8'h10, 10'h30F));
    send_word(10'h066, 1, mk(1, 1, 2'b11, 8'h54, 10'h066));
    send_word(T01,     1, mk(1, 0, 2'b01, 8'h54, T01));
    send_word(T10,     1, mk(1, 0, 2'b10, 8'h54, T10));

    // 1023 data words then a token: lock must hold
    for (int i = 0; i < 1023; i++) send_word(10'h100, 1, mk(1, 1, 2'b10, 8'h00, 10'h100));
    send_word(T00, 1, mk(1, 0, 2'b00, 8'h00, T00));
    expect_lock("lock_kept_1023", 1'b1);

    // 1024 data words: lock drops on the last one, which is still reported
    for (int i = 0; i < 1023; i++) send_word(10'h100, 1, mk(1, 1, 2'b00, 8'h00, 10'h100));
    send_word(10'h100, 1, mk(0, 1, 2'b00, 8'h00, 10'h100));
    expect_lock("lock_lost_1024", 1'b0);
    for (int i = 0; i < 3; i++) send_word(10'h100, 0, '0);
    expect_lock("still_unlocked", 1'b0);

    // Realign in SEARCH: 5 tokens, a one-bit slip, then 8 tokens
    do_reset(5);
    for (int i = 0; i < 5; i++) send_word(T00, 0, '0);
    drive_bit(1'b0);
    for (int i = 0; i < 7; i++) send_word(T00, 0, '0);
    expect_lock("slip_unlocked_after_7", 1'b0);
    for (int i = 0; i < 3; i++) send_word(T00, 1, mk(1, 0, 2'b00, 8'h00, T00));

    // Async reset mid-word while locked
    drive_bit(T11[0]);
    drive_bit(T11[1]);
    drive_bit(T11[2]);
    drive_bit(T11[3]);
    #2 resetn = 1'b0;
    #1 check_outputs_zero("async_reset");
    for (int i = 0; i < 4; i++) begin
      @(negedge shiftclk);
      serial_in = 1'($urandom_range(0, 1));
    end
    resetn    = 1'b1;
    serial_in = 1'b0;

    acquire("reacq");
    drive_bit(1'b0);
    drive_bit(1'b0);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmds_rx_channel.md
# tmds_rx_channel

Single-channel TMDS receiver for the DVI/HDMI video path. It is the receive-side counterpart of the pixel-clock TMDS encoder and 10:1 shift-out serializer. The block deserializes one recovered serial TMDS lane sampled at the bit clock. It finds the 10-bit word boundary from control tokens, decodes each word into 8-bit video data or a 2-bit control code, and flags lock. Three instances (red, green, blue) feed the sink-side timing recovery.

## Interface
Parameters:
- LOCK_COUNT, 8: consecutive boundary-aligned control tokens required to declare lock.
- TIMEOUT, 1024: consecutive locked words without any control token before lock is dropped. This must exceed the 800-word line length.

Ports:
- shiftclk  in  1  bit clock, 10x pixel rate; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- serial_in  in  1  TMDS serial bit, LSB of each word first, one bit per shiftclk.
- word_valid  out  1  one-cycle strobe; a new decoded word is on the outputs.
- tmds_word  out  10  raw aligned 10-bit word.
- vd  out  8  decoded video data; valid when de=1.
- cd  out  2  decoded control code {c1,c0}; valid when de=0.
- de  out  1  1 = data word, 0 = control token.
- locked  out  1  word alignment established.

## Operation
- Window: W = {serial_in, sr[9:1]}, where sr is the 10-bit shift register. On every edge, sr <= W. The bit sent first lands in W[0].
- Phase counter: `phase`, 4 bits, counts 0..9 and wraps 9 -> 0. A boundary edge is any edge with phase == 9.
- Control tokens, as W values: CD=00 is 10'b1101010100; CD=01 is 10'b0010101011; CD=10 is 10'b0101010100; CD=11 is 10'b1010101011. Any other value is a data word.
- Decode of data word q:
  - d = q[9] ? ~q[7:0] : q[7:0].
  - vd[0] = d[0].
  - For i = 1..7: vd[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- State machine, 2 states:
  - SEARCH:
    - Edge where W is a token and phase == 9: hits <= hits+1.
    - Edge where W is a token and phase != 9: phase <= 0 (this edge becomes a boundary) and hits <= 1.
    - Boundary edge where W is a non-token: hits <= 0.
    - Transition: when hits would reach LOCK_COUNT, go to LOCKED and clear the idle count.
    - No word_valid is issued in SEARCH.
  - LOCKED:
    - Phase wraps freely; no realignment.
    - On each boundary: latch W into tmds_word, update vd, cd and de, and pulse word_valid.
    - Token at a boundary: idle <= 0. Non-token at a boundary: idle <= idle+1.
    - Transition: when idle would reach TIMEOUT, return to SEARCH and clear hits, idle and locked. word_valid is still issued for that final word.
- On a token word, vd holds its previous value. On a data word, cd holds its previous value.
- Counter widths: hits is clog2(LOCK_COUNT+1) bits and idle is clog2(TIMEOUT+1) bits. Neither counter may wrap.

## Timing
- Reset (asynchronous, resetn = 0): sr=0, phase=0, state=SEARCH, hits=0, idle=0. All outputs 0: word_valid, tmds_word, vd, cd, de, locked.
- Latency: outputs update on the same edge that samples the 10th bit of a word. They are visible in the following cycle.
- Strobe: word_valid is high for exactly one cycle per 10 shiftclk while locked, and never two cycles in a row.
- Lock entry: locked rises on the edge that counts the LOCK_COUNT-th aligned token. word_valid rises with it, carrying that token (de=0).
- Reset mid-operation: all state clears immediately. Relock requires a fresh LOCK_COUNT token run.

## Test plan
- Reset: hold resetn=0 for 20 clocks with random serial_in -> all outputs 0 and locked=0.
- Acquisition: feed 3 junk bits, then 12 words of 10'b1101010100 -> locked=1 at the end of the 8th token, cd=00, de=0, word_valid period exactly 10 clocks.
- Decode, after lock:
  - Word 10'h100 -> de=1, vd=8'h00.
  - Word 10'h200 -> vd=8'hFF.
  - Token 10'b1010101011 -> de=0, cd=2'b11, vd unchanged.
- Realign in SEARCH: 5 aligned tokens, then 1 bit slip, then 8 tokens -> hits restarts at 1 after the slip, and locked rises only after the 8th post-slip token.
- Loss of lock: after lock, feed 1024 words of 10'h100 -> locked falls on the 1024th boundary. A 1023-word run followed by a token keeps lock.
- Async reset while locked mid-word -> outputs clear with no clock edge, and reacquisition behaves as in the acquisition scenario.
